// File: rtl/i2c_rx_seq_if.sv
// Command and byte-stream bundle of the i2c_rx receive sequencer.
// The slave side is the sequencer; the master side is the controller/consumer.
interface i2c_rx_seq_if #(
   parameter int LEN_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   logic [7:0]       m_data;
   logic             m_valid;
   logic             m_ready;
   logic             m_last;

   modport master (
      output cmd_valid, cmd_len, m_ready,
      input  cmd_ready, m_data, m_valid, m_last
   );

   modport slave (
      input  cmd_valid, cmd_len, m_ready,
      output cmd_ready, m_data, m_valid, m_last
   );
endinterface

// File: rtl/i2c_rx_seq.sv
// Receive sequencer for i2c_rx: one command reads cmd_len bytes, decides ACK/NACK
// per byte, and streams the bytes out of a small FIFO tagged with last.
module i2c_rx_seq #(
   parameter int DEPTH = 4,
   parameter int LEN_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   i2c_rx_seq_if.slave     s,
   output logic            rx_en,
   input  logic [7:0]      rx_data,
   input  logic            rx_data_rdy,
   input  logic            rx_ack_en,
   output logic            rx_ack,
   output logic            busy,
   output logic            done,
   output logic            overflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, RECV, LAST_ACK, DONE} state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             ack_q, ack_d;
   logic             rdy_prev_q, rdy_prev_d;
   logic             ack_en_prev_q, ack_en_prev_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [8:0]       mem_q [DEPTH];

   logic capture, full, push, pop, drop, is_last;

   // Full is judged on occupancy before any pop in the same cycle.
   always_comb begin
      capture = (state_q == RECV) && rx_data_rdy && !rdy_prev_q;
      full    = (count_q == CNT_W'(DEPTH));
      push    = capture && !full;
      drop    = capture && full;
      pop     = (count_q != '0) && s.m_ready;
      is_last = (({1'b0, cnt_q} + (LEN_W+1)'(1)) == {1'b0, len_q});
   end

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      ovf_d         = ovf_q;
      ack_d         = ack_q;
      rdy_prev_d    = rx_data_rdy;
      ack_en_prev_d = rx_ack_en;
      case (state_q)
         IDLE: begin
            if (s.cmd_valid) begin
               len_d   = s.cmd_len;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = (s.cmd_len == '0) ? DONE : RECV;
            end
         end
         RECV: begin
            if (capture) begin
               ack_d = drop || is_last;
               if (push) cnt_d = cnt_q + LEN_W'(1);
               if (drop) ovf_d = 1'b1;
               if (drop || is_last) state_d = LAST_ACK;
            end
         end
         LAST_ACK: begin
            if (ack_en_prev_q && !rx_ack_en) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         len_q         <= '0;
         cnt_q         <= '0;
         ovf_q         <= 1'b0;
         ack_q         <= 1'b1;
         rdy_prev_q    <= 1'b1;
         ack_en_prev_q <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         ovf_q         <= ovf_d;
         ack_q         <= ack_d;
         rdy_prev_q    <= rdy_prev_d;
         ack_en_prev_q <= ack_en_prev_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {is_last, rx_data};
   end

   always_comb begin
      s.cmd_ready = (state_q == IDLE);
      busy        = (state_q != IDLE);
      done        = (state_q == DONE);
      rx_en       = (state_q == RECV) || (state_q == LAST_ACK);
      rx_ack      = ack_q || (state_q == DONE);
      overflow    = ovf_q;
      s.m_valid   = (count_q != '0);
      s.m_data    = mem_q[rd_ptr_q][7:0];
      s.m_last    = s.m_valid && mem_q[rd_ptr_q][8];
   end
endmodule

// File: tb/tb_i2c_rx_seq.sv
// Randomised bench for i2c_rx_seq: a transaction-level model (byte queue plus
// expected control levels) is compared against the DUT on every falling edge.
module tb_i2c_rx_seq;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_en, rx_ack, busy, done, overflow;
   logic [7:0] rx_data;
   logic       rx_data_rdy, rx_ack_en;

   always #5 clk = ~clk;

   i2c_rx_seq_if #(.LEN_W(8)) bus ();

   i2c_rx_seq #(.DEPTH(DEPTH), .LEN_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .s           (bus),
      .rx_en       (rx_en),
      .rx_data     (rx_data),
      .rx_data_rdy (rx_data_rdy),
      .rx_ack_en   (rx_ack_en),
      .rx_ack      (rx_ack),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow)
   );

   int checks = 0;
   int failures = 0;

   logic [8:0] q[$];          // expected FIFO contents {last, data}
   logic [8:0] pop_log[$];    // what the DUT actually handed out
   logic [7:0] fixed_bytes[$];
   logic       ack_log[$];
   bit   pop_flag, chk_en;
   int   rdy_mode;
   bit   exp_rx_en, exp_busy, exp_done, exp_ovf, exp_ack;
   int   pops, lasts, done_seen, exp_done_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         pop_flag = 1'b0;
         if (chk_en) begin
            chk("rx_en", rx_en, exp_rx_en);
            chk("busy", busy, exp_busy);
            chk("cmd_ready", bus.cmd_ready, !exp_busy);
            chk("done", done, exp_done);
            chk("overflow", overflow, exp_ovf);
            chk("rx_ack", rx_ack, exp_ack);
            chk("m_valid", bus.m_valid, q.size() != 0);
            if (bus.m_valid && q.size() != 0) begin
               chk("m_data", bus.m_data, q[0][7:0]);
               chk("m_last", bus.m_last, q[0][8]);
            end
            if (done) done_seen++;
            if (bus.m_valid && bus.m_ready) begin
               pops++;
               if (bus.m_last) lasts++;
               pop_log.push_back({bus.m_last, bus.m_data});
               if (q.size() != 0) void'(q.pop_front());
               pop_flag = 1'b1;
            end
         end
      end
   end

   initial begin
      bus.m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q.delete();
      exp_rx_en = 0; exp_busy = 0; exp_done = 0; exp_ovf = 0; exp_ack = 1;
   endtask

   task automatic drain();
      int n = 0;
      rdy_mode = 1;
      while ((q.size() != 0 || bus.m_valid) && n < 60) begin
         tick();
         n++;
      end
      chk("drain_timeout", n < 60, 1);
      rdy_mode = 0;
      tick();
   endtask

   // Plays controller and datapath for one command; abort_after > 0 resets
   // the DUT once that many bytes have been accepted.
   task automatic do_cmd(input int len, input int abort_after);
      int cnt = 0;
      bit fin = 0;
      bit full;
      logic [7:0] b;
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = 8'(len);
      tick();
      bus.cmd_valid = 1'b0;
      exp_ovf  = 0;
      exp_busy = 1;
      if (len == 0) begin
         exp_done = 1; exp_done_cnt++;
         tick();
         exp_done = 0; exp_busy = 0;
         return;
      end
      exp_rx_en = 1;
      while (!fin) begin
         repeat ($urandom_range(1, 3)) tick();
         if (fixed_bytes.size() != 0) b = fixed_bytes.pop_front();
         else b = 8'($urandom);
         rx_data = b;
         rx_data_rdy = 1'b1;
         tick();
         rx_data_rdy = 1'b0;
         full = (q.size() + int'(pop_flag)) >= DEPTH;
         if (!full) begin
            cnt++;
            fin = (cnt == len);
            q.push_back({fin, b});
            exp_ack = fin;
         end else begin
            exp_ovf = 1;
            exp_ack = 1;
            fin = 1;
         end
         rx_ack_en = 1'b1;
         @(negedge clk);
         ack_log.push_back(rx_ack);
         tick();
         tick();
         rx_ack_en = 1'b0;
         tick();
         if (abort_after != 0 && cnt == abort_after && !fin) begin
            do_reset();
            return;
         end
      end
      exp_rx_en = 0; exp_done = 1; exp_done_cnt++;
      tick();
      exp_done = 0; exp_busy = 0;
   endtask

   initial begin
      int p0, l0, d0, n;
      logic [7:0] acks;
      rst = 1'b1; rx_data = '0; rx_data_rdy = 1'b0; rx_ack_en = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_len = '0; rdy_mode = 0; chk_en = 0;
      repeat (3) tick();
      rst = 1'b0;
      exp_rx_en = 0; exp_busy = 0; exp_done = 0; exp_ovf = 0; exp_ack = 1;
      chk_en = 1;
      @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_rx_ack", rx_ack, 1);
      chk("rst_m_valid", bus.m_valid, 0);
      tick();

      // single byte, consumer stalled
      ack_log.delete();
      fixed_bytes = '{8'h55};
      do_cmd(1, 0);
      @(negedge clk);
      chk("single_ack", ack_log[0], 1);
      chk("single_data", bus.m_data, 8'h55);
      chk("single_last", bus.m_last, 1);
      drain();

      // three bytes, consumer always ready
      ack_log.delete();
      fixed_bytes = '{8'hAA, 8'h55, 8'hF0};
      p0 = pops; l0 = lasts; d0 = done_seen;
      rdy_mode = 1;
      do_cmd(3, 0);
      drain();
      acks = {5'd0, ack_log[0], ack_log[1], ack_log[2]};
      chk("multi_acks", acks, 8'b001);
      chk("multi_pops", pops - p0, 3);
      chk("multi_lasts", lasts - l0, 1);
      chk("multi_done", done_seen - d0, 1);
      n = pop_log.size();
      chk("multi_b0", pop_log[n-3], 9'h0AA);
      chk("multi_b1", pop_log[n-2], 9'h055);
      chk("multi_b2", pop_log[n-1], 9'h1F0);

      // overflow: six requested, stalled consumer, fifth byte dropped
      ack_log.delete();
      do_cmd(6, 0);
      @(negedge clk);
      chk("ovf_flag", overflow, 1);
      chk("ovf_nacks", ack_log.size(), 5);
      acks = {3'd0, ack_log[0], ack_log[1], ack_log[2], ack_log[3], ack_log[4]};
      chk("ovf_acks", acks, 8'b00001);
      chk("ovf_model_depth", q.size(), 4);
      p0 = pops; l0 = lasts;
      drain();
      chk("ovf_pops", pops - p0, 4);
      chk("ovf_lasts", lasts - l0, 0);

      // back-to-back with the first byte still queued, then zero length
      fixed_bytes = '{8'h11, 8'h22, 8'h33};
      do_cmd(1, 0);
      do_cmd(2, 0);
      @(negedge clk);
      chk("b2b_ovf_clear", overflow, 0);
      d0 = done_seen;
      do_cmd(0, 0);
      @(negedge clk);
      chk("zero_done", done_seen - d0, 1);
      chk("zero_fifo_kept", bus.m_data, 8'h11);
      drain();
      n = pop_log.size();
      chk("b2b_e0", pop_log[n-3], 9'h111);
      chk("b2b_e1", pop_log[n-2], 9'h022);
      chk("b2b_e2", pop_log[n-1], 9'h133);

      // reset after one of three bytes
      do_cmd(3, 1);
      @(negedge clk);
      chk("rst_mid_rx_en", rx_en, 0);
      chk("rst_mid_m_valid", bus.m_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_rx_ack", rx_ack, 1);
      rx_data = 8'h77; rx_data_rdy = 1'b1;
      tick();
      rx_data_rdy = 1'b0;
      repeat (3) tick();

      // random lengths against a randomly stalling consumer
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         do_cmd($urandom_range(0, 6), 0);
         repeat ($urandom_range(0, 2)) tick();
      end
      drain();
      chk("done_count", done_seen, exp_done_cnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired actual=timeout required=finish");
      $fatal(1);
   end
endmodule
